// File: rtl/div_sqrt_arbiter_if.sv
// div_sqrt_arbiter_if
// Requester-side bundle for the shared div/sqrt unit arbiter.
// One bit (or lane) per requester for the request and response handshakes.
// The response data bus is shared by all requesters.
//   req_valid/req_ready   : per-requester request handshake
//   req_op                : 0 = div, 1 = sqrt
//   req_operand_a/b       : per-requester operands (C_OP bits each)
//   req_rm                : per-requester rounding mode (C_RM bits)
//   resp_valid/resp_ready : per-requester response handshake
//   resp_result           : shared 32-bit result
//   resp_flags            : shared flags {timeout, exp_of, exp_uf, div_zero}
// Modports:
//   master : the requester side
//   slave  : the arbiter side
interface div_sqrt_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int C_OP    = 32,
    parameter int C_RM    = 3
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           req_op;
    logic [NUM_REQ-1:0][C_OP-1:0] req_operand_a;
    logic [NUM_REQ-1:0][C_OP-1:0] req_operand_b;
    logic [NUM_REQ-1:0][C_RM-1:0] req_rm;
    logic [NUM_REQ-1:0]           resp_valid;
    logic [NUM_REQ-1:0]           resp_ready;
    logic [31:0]                  resp_result;
    logic [3:0]                   resp_flags;

    modport master (
        output req_valid, req_op, req_operand_a, req_operand_b, req_rm, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_flags
    );

    modport slave (
        input  req_valid, req_op, req_operand_a, req_operand_b, req_rm, resp_ready,
        output req_ready, resp_valid, resp_result, resp_flags
    );
endinterface

// File: rtl/div_sqrt_arbiter.sv
// div_sqrt_arbiter
// Shares one div/sqrt unit between NUM_REQ requesters with round-robin
// grants. It serves one transaction at a time and times out if the unit
// never reports done.
// Ports:
//   clk, rst        : clock; synchronous active-high reset
//   req_bus         : requester handshakes and response bus (slave modport)
//   div_start       : one-cycle start pulse to the unit for a divide
//   sqrt_start      : one-cycle start pulse to the unit for a square root
//   operand_a/b, rm : operands held for the unit during ISSUE and WAIT
//   unit_ready      : unit can accept work; grants are made only while it is high
//   unit_done       : unit finished; sampled only in WAIT
//   unit_result     : unit result, captured when unit_done is high
//   unit_exp_of/uf  : unit exponent overflow/underflow flags
//   unit_div_zero   : unit divide-by-zero flag
//   busy            : high whenever the FSM is not in IDLE
// NUM_REQ, C_OP and C_RM must match the connected interface instance.
//
// state | meaning
// IDLE  | pick a requester round-robin; handshake latches its request
// ISSUE | one-cycle div/sqrt start pulse with operands driven
// WAIT  | hold operands, wait for done or timeout
// RESP  | present result to the owner until it accepts
module div_sqrt_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 63,
    parameter int C_OP        = 32,
    parameter int C_RM        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    div_sqrt_arbiter_if.slave    req_bus,
    output logic                 div_start,
    output logic                 sqrt_start,
    output logic [C_OP-1:0]      operand_a,
    output logic [C_OP-1:0]      operand_b,
    output logic [C_RM-1:0]      rm,
    input  logic                 unit_ready,
    input  logic                 unit_done,
    input  logic [31:0]          unit_result,
    input  logic                 unit_exp_of,
    input  logic                 unit_exp_uf,
    input  logic                 unit_div_zero,
    output logic                 busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   last_grant, owner, grant_idx;
    logic [IDX_W:0]     cand;
    logic               grant_found, req_hs;
    logic               op_q;
    logic [C_OP-1:0]    a_q, b_q;
    logic [C_RM-1:0]    rm_q;
    logic [31:0]        result_q;
    logic [3:0]         flags_q;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [NUM_REQ-1:0] req_ready_d, resp_valid_d;
    logic               drive_unit;

    // Round-robin search from last_grant+1; cand is one bit wider so the
    // wrap-around subtraction never overflows.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_bus.req_valid[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Grant is purely combinational, so a requester that drops valid
    // before the handshake leaves no trace.
    assign req_hs = (state == IDLE) && unit_ready && grant_found && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        req_ready_d  = '0;
        resp_valid_d = '0;
        case (state)
            IDLE: begin
                if (req_hs) begin
                    req_ready_d[grant_idx] = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (unit_done || tmo_cnt == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid_d[owner] = 1'b1;
                if (req_bus.resp_ready[owner]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rm_q       <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        owner <= grant_idx;
                        op_q  <= req_bus.req_op[grant_idx];
                        a_q   <= req_bus.req_operand_a[grant_idx];
                        b_q   <= req_bus.req_operand_b[grant_idx];
                        rm_q  <= req_bus.req_rm[grant_idx];
                    end
                end
                // Load so that WAIT lasts exactly TIMEOUT_CYC cycles.
                ISSUE: tmo_cnt <= CNT_W'(TIMEOUT_CYC - 1);
                WAIT: begin
                    // done is checked first so it wins over a same-cycle timeout
                    if (unit_done) begin
                        result_q <= unit_result;
                        flags_q  <= {1'b0, unit_exp_of, unit_exp_uf, unit_div_zero};
                    end else if (tmo_cnt == '0) begin
                        result_q <= 32'h7FC0_0000;
                        flags_q  <= 4'b1000;
                    end else begin
                        tmo_cnt <= tmo_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (req_bus.resp_ready[owner]) begin
                        last_grant <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign drive_unit = (state == ISSUE) || (state == WAIT);
    assign div_start  = (state == ISSUE) && !op_q;
    assign sqrt_start = (state == ISSUE) && op_q;
    assign operand_a  = drive_unit ? a_q  : '0;
    assign operand_b  = drive_unit ? b_q  : '0;
    assign rm         = drive_unit ? rm_q : '0;
    assign busy       = (state != IDLE);

    assign req_bus.req_ready   = req_ready_d;
    assign req_bus.resp_valid  = resp_valid_d;
    assign req_bus.resp_result = (state == RESP) ? result_q : 32'h0;
    assign req_bus.resp_flags  = (state == RESP) ? flags_q  : 4'h0;
endmodule

// File: tb/tb_div_sqrt_arbiter.sv
// tb_div_sqrt_arbiter
// Directed bench for div_sqrt_arbiter with NUM_REQ = 2.
// Tests push their expected unit starts and responses into queues.
// Monitors pop and compare those entries whenever the DUT pulses a start
// or raises resp_valid.
// A small unit model answers each start after a latency taken from its own
// queue; a latency of 0 means it never answers.
module tb_div_sqrt_arbiter;
    localparam int NUM_REQ     = 2;
    localparam int C_OP        = 32;
    localparam int C_RM        = 3;
    localparam int TIMEOUT_CYC = 63;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_sqrt_arbiter_if #(.NUM_REQ(NUM_REQ), .C_OP(C_OP), .C_RM(C_RM)) bus ();

    logic        div_start, sqrt_start, busy;
    logic [31:0] operand_a, operand_b;
    logic [2:0]  rm;
    logic        unit_ready, unit_done, done_model, done_stray;
    logic [31:0] unit_result;
    logic        unit_exp_of, unit_exp_uf, unit_div_zero;

    assign unit_done = done_model | done_stray;

    div_sqrt_arbiter #(
        .NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC), .C_OP(C_OP), .C_RM(C_RM)
    ) dut (
        .clk(clk), .rst(rst), .req_bus(bus.slave),
        .div_start(div_start), .sqrt_start(sqrt_start),
        .operand_a(operand_a), .operand_b(operand_b), .rm(rm),
        .unit_ready(unit_ready), .unit_done(unit_done), .unit_result(unit_result),
        .unit_exp_of(unit_exp_of), .unit_exp_uf(unit_exp_uf), .unit_div_zero(unit_div_zero),
        .busy(busy)
    );

    typedef struct { logic sqrt; logic [31:0] a; logic [31:0] b; logic [2:0] r; int at; } issue_t;
    typedef struct { logic [1:0] vec; logic [31:0] res; logic [3:0] fl; int rise; } resp_t;
    typedef struct { int lat; logic [31:0] res; logic [2:0] fl; } unit_t;

    issue_t issue_q[$];
    resp_t  resp_q[$];
    unit_t  unit_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unit model
    initial begin
        unit_t u;
        done_model = 1'b0;
        unit_result = 32'hDEAD_BEEF;
        {unit_exp_of, unit_exp_uf, unit_div_zero} = 3'b111;
        forever begin
            @(negedge clk);
            if (!rst && (div_start || sqrt_start) && unit_q.size() > 0) begin
                u = unit_q.pop_front();
                if (u.lat > 0) begin
                    repeat (u.lat) @(posedge clk);
                    #1;
                    done_model = 1'b1;
                    unit_result = u.res;
                    {unit_exp_of, unit_exp_uf, unit_div_zero} = u.fl;
                    @(posedge clk);
                    #1;
                    done_model = 1'b0;
                    unit_result = 32'hDEAD_BEEF;
                    {unit_exp_of, unit_exp_uf, unit_div_zero} = 3'b111;
                end
            end
        end
    end

    // Monitors
    resp_t       cur;
    logic [1:0]  prev_valid = 2'b00;
    logic [31:0] held_res;
    logic [3:0]  held_fl;

    always @(negedge clk) begin
        issue_t e;
        if (rst) begin
            prev_valid = 2'b00;
        end else begin
            if (div_start || sqrt_start) begin
                if (issue_q.size() == 0) begin
                    check("start_unexpected", {div_start, sqrt_start}, 2'b00);
                end else begin
                    e = issue_q.pop_front();
                    check("start_kind", {div_start, sqrt_start}, e.sqrt ? 2'b01 : 2'b10);
                    check("start_cycle", cyc, e.at);
                    check("start_op_a", operand_a, e.a);
                    check("start_op_b", operand_b, e.b);
                    check("start_rm", rm, e.r);
                end
            end
            if (bus.req_ready != 2'b00) begin
                check("req_ready_onehot", $onehot(bus.req_ready), 1);
            end
            if (bus.resp_valid != 2'b00) begin
                if (prev_valid == 2'b00) begin
                    if (resp_q.size() == 0) begin
                        check("resp_unexpected", bus.resp_valid, 2'b00);
                    end else begin
                        cur = resp_q.pop_front();
                        check("resp_vec", bus.resp_valid, cur.vec);
                        check("resp_result", bus.resp_result, cur.res);
                        check("resp_flags", bus.resp_flags, cur.fl);
                        if (cur.rise >= 0) check("resp_rise_cycle", cyc, cur.rise);
                    end
                    held_res = bus.resp_result;
                    held_fl  = bus.resp_flags;
                end else begin
                    check("resp_held_vec", bus.resp_valid, prev_valid);
                    check("resp_stable", {bus.resp_result, bus.resp_flags}, {held_res, held_fl});
                end
            end else begin
                check("resp_idle_zero", {bus.resp_result, bus.resp_flags}, 36'h0);
            end
            prev_valid = bus.resp_valid;
        end
    end

    task automatic do_req(input int idx, input logic sqrt, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] r, input int lat, input logic [31:0] ures, input logic [2:0] ufl,
                          input logic [1:0] evec, input logic [31:0] eres, input logic [3:0] efl,
                          input int rise_off, output int t_hs);
        unit_t  u;
        issue_t is;
        resp_t  rs;
        u.lat = lat; u.res = ures; u.fl = ufl;
        unit_q.push_back(u);
        bus.req_valid[idx]     = 1'b1;
        bus.req_op[idx]        = sqrt;
        bus.req_operand_a[idx] = a;
        bus.req_operand_b[idx] = b;
        bus.req_rm[idx]        = r;
        t_hs = -1;
        for (int k = 0; k < 200 && t_hs < 0; k++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) begin
                t_hs = cyc;
                is.sqrt = sqrt; is.a = a; is.b = b; is.r = r; is.at = cyc + 1;
                issue_q.push_back(is);
                rs.vec = evec; rs.res = eres; rs.fl = efl;
                rs.rise = (rise_off < 0) ? -1 : cyc + rise_off;
                resp_q.push_back(rs);
            end
            tick();
        end
        bus.req_valid[idx] = 1'b0;
        if (t_hs < 0) check("req_grant_timeout", bus.req_ready[idx], 1'b1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || issue_q.size() != 0 || bus.resp_valid != 2'b00) && n < 300) begin
            tick();
            n++;
        end
        check("drain_done", resp_q.size() + issue_q.size(), 0);
        tick();
    endtask

    logic [1:0]  cvec [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] cres [2] = '{32'h40A0_0000, 32'h4040_0000};

    initial begin
        int t, t1, t2, k;
        logic [1:0] hs, drop;
        issue_t is;
        resp_t  rs;
        unit_t  u;

        rst = 1'b1;
        unit_ready = 1'b1;
        done_stray = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_op = 2'b00;
        bus.req_operand_a = '0;
        bus.req_operand_b = '0;
        bus.req_rm = '0;
        bus.resp_ready = 2'b11;

        // Reset: all outputs low even with requests pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_resp", {bus.resp_valid, bus.resp_result, bus.resp_flags}, 38'h0);
        check("rst_unit_ctl", {div_start, sqrt_start, busy, rm, operand_a}, 38'h0);
        check("rst_op_b", operand_b, 32'h0);
        tick();
        rst = 1'b0;
        bus.req_valid = 2'b00;

        // Unit not ready: no grant, no start
        unit_ready = 1'b0;
        bus.req_valid = 2'b01;
        repeat (5) begin
            @(negedge clk);
            check("unit_busy_no_grant", bus.req_ready, 2'b00);
            check("unit_busy_idle", busy, 1'b0);
            tick();
        end
        bus.req_valid = 2'b00;
        unit_ready = 1'b1;
        tick();

        // Single div 3.0 / 1.0, done 12 cycles after the start
        do_req(0, 1'b0, 32'h4040_0000, 32'h3F80_0000, 3'd0, 12, 32'h4040_0000, 3'b000,
               2'b01, 32'h4040_0000, 4'b0000, 14, t);
        wait_drain();

        // Sqrt 4.0 with 5 cycles of response backpressure
        bus.resp_ready = 2'b01;
        do_req(1, 1'b1, 32'h4080_0000, 32'h0, 3'd2, 3, 32'h4000_0000, 3'b000,
               2'b10, 32'h4000_0000, 4'b0000, 5, t);
        for (int n = 0; n < 20 && cyc < t + 5; n++) tick();
        bus.req_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_resp_held", bus.resp_valid, 2'b10);
            check("bp_no_grant", bus.req_ready, 2'b00);
            tick();
        end
        bus.req_valid[0] = 1'b0;
        bus.resp_ready = 2'b11;
        wait_drain();

        // Timeout, then minimum spacing, then done-vs-timeout edges
        do_req(0, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 3'd1, 0, 32'h0, 3'b000,
               2'b01, 32'h7FC0_0000, 4'b1000, 65, t);
        do_req(1, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 1, 32'h3F80_0000, 3'b000,
               2'b10, 32'h3F80_0000, 4'b0000, 3, t1);
        do_req(0, 1'b0, 32'h4080_0000, 32'h4000_0000, 3'd0, 1, 32'h4000_0000, 3'b000,
               2'b01, 32'h4000_0000, 4'b0000, 3, t2);
        check("min_spacing", t2 - t1, 4);
        do_req(1, 1'b0, 32'h3F80_0000, 32'h0, 3'd3, 63, 32'h7F80_0000, 3'b001,
               2'b10, 32'h7F80_0000, 4'b0001, 65, t);
        do_req(0, 1'b0, 32'h7F00_0000, 32'h0080_0000, 3'd4, 62, 32'h7F80_0000, 3'b100,
               2'b01, 32'h7F80_0000, 4'b0100, 64, t);
        wait_drain();

        // Reset during WAIT, then a stray done in IDLE
        do_req(1, 1'b1, 32'h4080_0000, 32'h0, 3'd0, 0, 32'h0, 3'b000,
               2'b10, 32'h0, 4'b0000, -1, t);
        resp_q.delete();
        repeat (3) tick();
        @(negedge clk);
        check("midop_busy", busy, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_stray = 1'b1;
        tick();
        done_stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midop_idle", {busy, bus.resp_valid}, 3'b000);
            tick();
        end

        // Contention from reset: order 0, 1, 0, 1
        for (int i = 0; i < 4; i++) begin
            u.lat = 2; u.res = cres[i % 2]; u.fl = 3'b000;
            unit_q.push_back(u);
        end
        bus.req_op            = 2'b10;
        bus.req_operand_a[0]  = 32'h4120_0000;
        bus.req_operand_b[0]  = 32'h4000_0000;
        bus.req_rm[0]         = 3'd1;
        bus.req_operand_a[1]  = 32'h4110_0000;
        bus.req_operand_b[1]  = 32'h0;
        bus.req_rm[1]         = 3'd2;
        bus.req_valid         = 2'b11;
        k = 0;
        for (int c = 0; c < 100 && k < 4; c++) begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            drop = 2'b00;
            if (hs != 2'b00) begin
                check("grant_order", hs, cvec[k]);
                is.sqrt = (k % 2 == 1);
                is.a    = (k % 2 == 1) ? 32'h4110_0000 : 32'h4120_0000;
                is.b    = (k % 2 == 1) ? 32'h0 : 32'h4000_0000;
                is.r    = (k % 2 == 1) ? 3'd2 : 3'd1;
                is.at   = cyc + 1;
                issue_q.push_back(is);
                rs.vec = cvec[k]; rs.res = cres[k % 2]; rs.fl = 4'b0000; rs.rise = cyc + 4;
                resp_q.push_back(rs);
                if (k >= 2) drop = cvec[k];
                k++;
            end
            tick();
            bus.req_valid = bus.req_valid & ~drop;
        end
        check("contention_grants", k, 4);
        bus.req_valid = 2'b00;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_sqrt_arbiter.md
DIV_SQRT_ARBITER -- requirements
Module: div_sqrt_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing one div/sqrt unit (range 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 63, SHALL set the maximum cycles waited for unit done before an error response.
REQ-003 Clk_CI  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Rst_RI  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 Req_valid_SI / Req_ready_SO  in/out  NUM_REQ  SHALL be the per-requester request handshake.
REQ-006 Req_op_SI  in  NUM_REQ  SHALL select the operation per requester: 0 = div, 1 = sqrt.
REQ-007 Req_operand_a_DI, Req_operand_b_DI  in  NUM_REQ x C_OP; Req_rm_SI  in  NUM_REQ x C_RM  SHALL carry the per-requester operands and rounding mode.
REQ-008 Resp_valid_SO / Resp_ready_SI  out/in  NUM_REQ  SHALL be the per-requester response handshake.
REQ-009 Resp_result_DO  out  32 and Resp_flags_DO  out  4 SHALL be the shared response bus; flags are {Timeout, Exp_OF, Exp_UF, Div_zero}.
REQ-010 Div_start_SO, Sqrt_start_SO  out  1; Operand_a_DO, Operand_b_DO  out  C_OP; RM_SO  out  C_RM  SHALL drive the shared unit.
REQ-011 Unit_ready_SI, Unit_done_SI  in  1; Unit_result_DI  in  32; Unit_exp_of_SI, Unit_exp_uf_SI, Unit_div_zero_SI  in  1  SHALL be the unit's status and result inputs.
REQ-012 Busy_SO  out  1 SHALL be high in every state except IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: when at least one Req_valid_SI is high and Unit_ready_SI = 1, the FSM SHALL grant exactly one requester, chosen round-robin starting at last_grant+1 (mod NUM_REQ).
REQ-015 Req_ready_SO SHALL be combinational, one-hot or zero, high only for the granted index in IDLE, and zero in all other states.
REQ-016 On the request handshake, the FSM SHALL register operands, op, rm and owner index, then go to ISSUE.
REQ-017 ISSUE SHALL last exactly one cycle: Div_start_SO (op = 0) or Sqrt_start_SO (op = 1) pulses high for that cycle only, then the FSM goes to WAIT.
REQ-018 Operand_a_DO, Operand_b_DO and RM_SO SHALL hold the registered values from ISSUE until the FSM leaves WAIT; they are 0 in IDLE.
REQ-019 WAIT: on Unit_done_SI = 1, the FSM SHALL capture Unit_result_DI and the three unit flags, clear Timeout, and go to RESP.
REQ-020 WAIT: a counter SHALL count cycles spent in WAIT; if it reaches TIMEOUT_CYC without done, the FSM SHALL set result to 32'h7FC00000, flags to 4'b1000, and go to RESP.
REQ-021 If done and the timeout occur in the same cycle, done SHALL win.
REQ-022 Unit_done_SI SHALL be ignored in IDLE, ISSUE and RESP.
REQ-023 RESP: Resp_valid_SO[owner] SHALL be high and all other bits low; Resp_result_DO and Resp_flags_DO SHALL be stable until the handshake.
REQ-024 On Resp_ready_SI[owner] = 1, last_grant SHALL be set to owner and the FSM SHALL return to IDLE; no new grant is made in that cycle.
REQ-025 Latency: for a request accepted at cycle T with unit done at T+1+L, Resp_valid_SO SHALL rise at T+2+L; minimum request-to-request spacing is 4 cycles.
REQ-026 Resp_result_DO and Resp_flags_DO SHALL be 0 whenever no Resp_valid_SO bit is high.
REQ-027 A requester deasserting Req_valid_SI before its handshake SHALL lose its grant with no side effects.

Reset
REQ-028 On Rst_RI = 1 at a clock edge: state = IDLE, last_grant = NUM_REQ-1 (so requester 0 has priority first), timeout counter = 0, and all registered data = 0.
REQ-029 During and after reset, all outputs SHALL be 0.
REQ-030 A reset mid-operation SHALL abandon the transaction and produce no response; a late Unit_done_SI from the abandoned operation is ignored per REQ-022.

Verification
REQ-031 Single div: req0, a = 0x40400000 (3.0), b = 0x3F800000 (1.0), unit done after 12 cycles -> one Div_start_SO pulse; Resp_valid_SO = 2'b01 at T+14; result = 0x40400000.
REQ-032 Contention: req0 and req1 valid together from reset, both held -> grant order 0, 1, 0, 1; Req_ready_SO never has two bits high.
REQ-033 Sqrt plus backpressure: req1 sqrt of 0x40800000 (4.0); Resp_ready_SI low for 5 cycles -> Resp_valid_SO = 2'b10 held with result 0x40000000 stable throughout; no new grant until the handshake.
REQ-034 Timeout: unit never asserts done -> after 63 WAIT cycles, response is 0x7FC00000 with flags 4'b1000; the FSM then accepts the next request.
REQ-035 Mid-op reset: reset asserted in WAIT, then a stray Unit_done_SI arrives in IDLE -> no Resp_valid_SO; next grant goes to requester 0.
REQ-036 Unit_ready_SI = 0 while requests are pending -> Req_ready_SO stays 0 and no start pulse is issued.
